// File: rtl/tx_intf_pkg.sv
// rtl/tx_intf_pkg.sv - shared types and constants for the tx interface try tracker
package tx_intf_pkg;

  localparam int SN_W_DEF           = 10;
  localparam int TX_STATUS_FAIL_BIT = 4;
  localparam int TX_STATUS_CNT_MSB  = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TX,
    ST_WAIT_ACK,
    ST_RETRANS,
    ST_WAIT_RESTART,
    ST_REPORT
  } tx_state_e;

endpackage

// File: rtl/ack_wait_timer.sv
// rtl/ack_wait_timer.sv - ACK wait counter; expires on the last cycle of the wait window
module ack_wait_timer #(
  parameter int TIMER_W = 16
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               load,
  input  logic               en,
  input  logic [TIMER_W-1:0] ack_timeout_top,
  output logic               expire
);

  logic [TIMER_W-1:0] count;
  logic [TIMER_W-1:0] last;

  // A zero top still gives a one-cycle window.
  always_comb begin
    last = '0;
    if (ack_timeout_top != '0) last = ack_timeout_top - TIMER_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (en) begin
      count <= count + TIMER_W'(1);
    end
  end

  assign expire = en && (count == last);

endmodule

// File: rtl/tx_try_tracker.sv
// rtl/tx_try_tracker.sv - follows one packet through tx, ACK wait and retries, emits one completion record
module tx_try_tracker
  import tx_intf_pkg::*;
#(
  parameter int TIMER_W = 16,
  parameter int SN_W    = SN_W_DEF
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               tx_start,
  input  logic               tx_end,
  input  logic               pkt_need_ack,
  input  logic [1:0]         pkt_linux_prio,
  input  logic [1:0]         pkt_queue_idx,
  input  logic [SN_W-1:0]    pkt_sn,
  input  logic [3:0]         max_num_retrans,
  input  logic [TIMER_W-1:0] ack_timeout_top,
  input  logic               ack_rx,
  input  logic               ack_addr_match,
  output logic               retrans_req,
  output logic               busy,
  output logic               tx_try_complete,
  output logic [4:0]         tx_status,
  output logic [1:0]         linux_prio,
  output logic [1:0]         tx_queue_idx,
  output logic [SN_W-1:0]    tx_pkt_sn
);

  tx_state_e state, next_state;

  logic            lat_need_ack;
  logic [1:0]      lat_prio;
  logic [1:0]      lat_queue_idx;
  logic [SN_W-1:0] lat_sn;
  logic [3:0]      lat_max;
  logic [3:0]      retrans_cnt;

  logic latch_pkt;
  logic timer_load;
  logic timer_en;
  logic timer_expire;
  logic cnt_inc;
  logic report_en;
  logic report_fail;

  ack_wait_timer #(
    .TIMER_W(TIMER_W)
  ) u_timer (
    .clk             (clk),
    .rstn            (rstn),
    .load            (timer_load),
    .en              (timer_en),
    .ack_timeout_top (ack_timeout_top),
    .expire          (timer_expire)
  );

  always_ff @(posedge clk) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state      = state;
    retrans_req     = 1'b0;
    tx_try_complete = 1'b0;
    latch_pkt       = 1'b0;
    timer_load      = 1'b0;
    timer_en        = 1'b0;
    cnt_inc         = 1'b0;
    report_en       = 1'b0;
    report_fail     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (tx_start) begin
          latch_pkt  = 1'b1;
          next_state = ST_TX;
        end
      end
      ST_TX: begin
        if (tx_end) begin
          if (lat_need_ack) begin
            timer_load = 1'b1;
            next_state = ST_WAIT_ACK;
          end else begin
            report_en  = 1'b1;
            next_state = ST_REPORT;
          end
        end
      end
      ST_WAIT_ACK: begin
        timer_en = 1'b1;
        // A matched ACK takes priority over a timeout in the same cycle.
        if (ack_rx && ack_addr_match) begin
          report_en  = 1'b1;
          next_state = ST_REPORT;
        end else if (timer_expire) begin
          if (retrans_cnt == lat_max) begin
            report_en   = 1'b1;
            report_fail = 1'b1;
            next_state  = ST_REPORT;
          end else begin
            next_state = ST_RETRANS;
          end
        end
      end
      ST_RETRANS: begin
        retrans_req = 1'b1;
        cnt_inc     = 1'b1;
        next_state  = ST_WAIT_RESTART;
      end
      ST_WAIT_RESTART: begin
        if (tx_start) next_state = ST_TX;
      end
      ST_REPORT: begin
        tx_try_complete = 1'b1;
        next_state      = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      lat_need_ack  <= 1'b0;
      lat_prio      <= '0;
      lat_queue_idx <= '0;
      lat_sn        <= '0;
      lat_max       <= '0;
      retrans_cnt   <= '0;
    end else if (latch_pkt) begin
      lat_need_ack  <= pkt_need_ack;
      lat_prio      <= pkt_linux_prio;
      lat_queue_idx <= pkt_queue_idx;
      lat_sn        <= pkt_sn;
      lat_max       <= max_num_retrans;
      retrans_cnt   <= '0;
    end else if (cnt_inc && (retrans_cnt != 4'hF)) begin
      retrans_cnt <= retrans_cnt + 4'd1;
    end
  end

  // Record outputs change only on the way into REPORT and then hold.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      tx_status    <= '0;
      linux_prio   <= '0;
      tx_queue_idx <= '0;
      tx_pkt_sn    <= '0;
    end else if (report_en) begin
      tx_status[TX_STATUS_FAIL_BIT]  <= report_fail;
      tx_status[TX_STATUS_CNT_MSB:0] <= retrans_cnt;
      linux_prio                     <= lat_prio;
      tx_queue_idx                   <= lat_queue_idx;
      tx_pkt_sn                      <= lat_sn;
    end
  end

endmodule

// File: tb/tb_tx_try_tracker.sv
// tb/tb_tx_try_tracker.sv - self-checking bench for tx_try_tracker
module tb_tx_try_tracker;

  localparam int TIMER_W = 16;
  localparam int SN_W    = 10;

  logic               clk = 1'b0;
  logic               rstn;
  logic               tx_start, tx_end, pkt_need_ack;
  logic [1:0]         pkt_linux_prio, pkt_queue_idx;
  logic [SN_W-1:0]    pkt_sn;
  logic [3:0]         max_num_retrans;
  logic [TIMER_W-1:0] ack_timeout_top;
  logic               ack_rx, ack_addr_match;
  logic               retrans_req, busy, tx_try_complete;
  logic [4:0]         tx_status;
  logic [1:0]         linux_prio, tx_queue_idx;
  logic [SN_W-1:0]    tx_pkt_sn;

  always #5 clk = ~clk;

  tx_try_tracker #(.TIMER_W(TIMER_W), .SN_W(SN_W)) dut (
    .clk(clk), .rstn(rstn), .tx_start(tx_start), .tx_end(tx_end),
    .pkt_need_ack(pkt_need_ack), .pkt_linux_prio(pkt_linux_prio),
    .pkt_queue_idx(pkt_queue_idx), .pkt_sn(pkt_sn),
    .max_num_retrans(max_num_retrans), .ack_timeout_top(ack_timeout_top),
    .ack_rx(ack_rx), .ack_addr_match(ack_addr_match),
    .retrans_req(retrans_req), .busy(busy), .tx_try_complete(tx_try_complete),
    .tx_status(tx_status), .linux_prio(linux_prio),
    .tx_queue_idx(tx_queue_idx), .tx_pkt_sn(tx_pkt_sn)
  );

  typedef logic [3:0][7:0] dly_t;

  typedef struct {
    logic       need_ack;
    logic [1:0] prio;
    logic [1:0] q;
    logic [9:0] sn;
    logic [3:0] maxr;
    int         top;
    int         txlen;
    dly_t       ack_d;
    dly_t       unm_d;
    logic [4:0] exp_status;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic dly_t mk(input int a0, input int a1, input int a2, input int a3);
    return {8'(a3), 8'(a2), 8'(a1), 8'(a0)};
  endfunction

  // Outcome of try i: a matched ACK inside the window wins, else the window
  // closes at its last cycle and either retries or gives up at the limit.
  function automatic void model_try(input int i, input int teff, input int maxr,
                                    input int ad, output int ecyc, output int kind);
    if (ad < teff) begin
      ecyc = ad;
      kind = 0;
    end else begin
      ecyc = teff - 1;
      kind = (i == maxr) ? 1 : 2;
    end
  endfunction

  task automatic check_report(input vec_t v, input int fail, input int cnt,
                              output logic [4:0] got_status);
    chk("complete", {tx_try_complete, retrans_req}, 2'b10);
    chk("status", tx_status, (fail << 4) | cnt);
    chk("meta", {linux_prio, tx_queue_idx, tx_pkt_sn}, {v.prio, v.q, v.sn});
    got_status = tx_status;
    step();
    chk("idle_after", {busy, tx_try_complete}, 0);
    chk("hold_meta", {tx_status, tx_pkt_sn}, {got_status, v.sn});
  endtask

  task automatic run_pkt(input vec_t v, output logic [4:0] got_status);
    int  teff, ecyc, kind;
    bit  done;
    teff = (v.top == 0) ? 1 : v.top;
    got_status = 5'h1f;
    done = 0;
    pkt_need_ack    = v.need_ack;
    pkt_linux_prio  = v.prio;
    pkt_queue_idx   = v.q;
    pkt_sn          = v.sn;
    max_num_retrans = v.maxr;
    ack_timeout_top = TIMER_W'(v.top);
    tx_start = 1'b1;
    step();
    tx_start = 1'b0;
    // Anything upstream presents after the first start must be ignored.
    pkt_need_ack    = 1'($urandom);
    pkt_linux_prio  = 2'($urandom);
    pkt_queue_idx   = 2'($urandom);
    pkt_sn          = SN_W'($urandom);
    max_num_retrans = 4'($urandom);
    for (int i = 0; i < 4 && !done; i++) begin
      for (int t = 0; t < v.txlen; t++) begin
        tx_start = 1'($urandom);
        step();
        chk("tx_busy", {busy, tx_try_complete}, 2'b10);
      end
      tx_start = 1'b0;
      tx_end = 1'b1;
      step();
      tx_end = 1'b0;
      if (!v.need_ack) begin
        check_report(v, 0, 0, got_status);
        done = 1;
      end else begin
        model_try(i, teff, int'(v.maxr), int'(v.ack_d[i]), ecyc, kind);
        for (int c = 0; c <= ecyc; c++) begin
          ack_rx         = (c == int'(v.ack_d[i])) || (c == int'(v.unm_d[i]));
          ack_addr_match = (c == int'(v.ack_d[i]));
          step();
          ack_rx = 1'b0;
          ack_addr_match = 1'b0;
          if (c < ecyc) chk("wait_quiet", {tx_try_complete, retrans_req}, 0);
        end
        if (kind == 2) begin
          chk("retrans_req", {tx_try_complete, retrans_req}, 2'b01);
          step();
          chk("restart_wait", {busy, retrans_req}, 2'b10);
          for (int g = 0; g < int'($urandom_range(0, 3)); g++) step();
          pkt_sn   = SN_W'($urandom);
          tx_start = 1'b1;
          step();
          tx_start = 1'b0;
        end else begin
          check_report(v, kind, i, got_status);
          done = 1;
        end
      end
    end
    if (!done) chk("pkt_terminated", 0, 1);
  endtask

  vec_t       vecs[8];
  vec_t       rv;
  logic [4:0] st;
  int         teff;

  initial begin
    rstn = 1'b0;
    tx_start = 1'b0; tx_end = 1'b0; pkt_need_ack = 1'b0;
    pkt_linux_prio = '0; pkt_queue_idx = '0; pkt_sn = '0;
    max_num_retrans = '0; ack_timeout_top = '0;
    ack_rx = 1'b0; ack_addr_match = 1'b0;
    step();
    step();
    chk("reset_ctrl", {busy, tx_try_complete, retrans_req}, 0);
    chk("reset_rec", {tx_status, linux_prio, tx_queue_idx, tx_pkt_sn}, 0);
    rstn = 1'b1;
    step();

    vecs[0] = '{1'b0, 2'd2, 2'd1, 10'h155, 4'd0, 0,   50, mk(-1,-1,-1,-1), mk(-1,-1,-1,-1), 5'h00};
    vecs[1] = '{1'b1, 2'd1, 2'd3, 10'h0a3, 4'd3, 100, 3,  mk(39,-1,-1,-1), mk(-1,-1,-1,-1), 5'h00};
    vecs[2] = '{1'b1, 2'd0, 2'd2, 10'h2f1, 4'd3, 20,  3,  mk(-1,-1,5,-1),  mk(-1,-1,-1,-1), 5'h02};
    vecs[3] = '{1'b1, 2'd3, 2'd0, 10'h3ff, 4'd2, 10,  2,  mk(-1,-1,-1,-1), mk(-1,-1,-1,-1), 5'h12};
    vecs[4] = '{1'b1, 2'd2, 2'd2, 10'h011, 4'd1, 8,   1,  mk(7,-1,-1,-1),  mk(-1,-1,-1,-1), 5'h00};
    vecs[5] = '{1'b1, 2'd1, 2'd1, 10'h222, 4'd1, 8,   1,  mk(-1,2,-1,-1),  mk(3,-1,-1,-1),  5'h01};
    vecs[6] = '{1'b1, 2'd0, 2'd3, 10'h1c4, 4'd1, 0,   0,  mk(-1,0,-1,-1),  mk(-1,-1,-1,-1), 5'h01};
    vecs[7] = '{1'b1, 2'd3, 2'd1, 10'h0f0, 4'd0, 5,   2,  mk(-1,-1,-1,-1), mk(-1,-1,-1,-1), 5'h10};

    for (int k = 0; k < 8; k++) begin
      run_pkt(vecs[k], st);
      chk($sformatf("table_status_%0d", k), st, vecs[k].exp_status);
    end

    // Reset in the middle of an ACK wait drops the packet silently.
    pkt_need_ack = 1'b1; pkt_sn = 10'h123; max_num_retrans = 4'd3;
    ack_timeout_top = 16'd50;
    tx_start = 1'b1; step(); tx_start = 1'b0;
    step(); step();
    tx_end = 1'b1; step(); tx_end = 1'b0;
    for (int c = 0; c < 5; c++) step();
    chk("pre_reset_busy", busy, 1);
    rstn = 1'b0; step(); rstn = 1'b1;
    chk("post_reset", {busy, tx_try_complete, retrans_req, tx_status}, 0);
    begin
      int seen = 0;
      for (int c = 0; c < 60; c++) begin
        step();
        seen |= {busy, tx_try_complete, retrans_req};
      end
      chk("post_reset_quiet", seen, 0);
    end
    run_pkt('{1'b1, 2'd2, 2'd3, 10'h2aa, 4'd1, 6, 2, mk(-1,4,-1,-1), mk(-1,-1,-1,-1), 5'h01}, st);
    chk("fresh_after_reset", st, 5'h01);

    for (int k = 0; k < 40; k++) begin
      rv.need_ack = 1'($urandom);
      rv.prio     = 2'($urandom);
      rv.q        = 2'($urandom);
      rv.sn       = 10'($urandom);
      rv.maxr     = 4'($urandom_range(0, 3));
      rv.top      = int'($urandom_range(0, 12));
      rv.txlen    = int'($urandom_range(0, 4));
      teff = (rv.top == 0) ? 1 : rv.top;
      for (int i = 0; i < 4; i++) begin
        rv.ack_d[i] = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom_range(0, teff + 1));
        rv.unm_d[i] = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom_range(0, teff));
      end
      rv.exp_status = '0;
      run_pkt(rv, st);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tx_try_tracker.md
Name: tx_try_tracker

Overview:
- Tracks one transmitted packet from the first PHY start through ACK wait and any retransmissions, then emits a single completion record.
- The record carries linux_prio, queue index, packet SN and a 5-bit status. It drives the tx status FIFO stage directly downstream: tx_try_complete maps to its write-enable path, and the metadata maps to its data inputs.
- Sits in tx_intf between the queue/DMA control and the status FIFO.

Parameters:
- TIMER_W, 16, width of the ACK-timeout counter and of ack_timeout_top.
- SN_W, 10, packet sequence-number width.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- tx_start  in  1  single-cycle pulse: PHY begins sending a packet (first try or retransmission)
- tx_end  in  1  single-cycle pulse: PHY finished sending the packet
- pkt_need_ack  in  1  current packet expects an ACK
- pkt_linux_prio  in  2  priority of current packet
- pkt_queue_idx  in  2  hardware queue of current packet
- pkt_sn  in  SN_W  sequence number of current packet
- max_num_retrans  in  4  retransmission limit (register value)
- ack_timeout_top  in  TIMER_W  ACK wait length in clk cycles
- ack_rx  in  1  pulse: ACK frame decoded
- ack_addr_match  in  1  qualifies ack_rx; valid in the same cycle as ack_rx
- retrans_req  out  1  single-cycle pulse requesting the queue logic to resend
- busy  out  1  high whenever state != IDLE
- tx_try_complete  out  1  single-cycle completion pulse
- tx_status  out  5  {fail, retrans_cnt[3:0]}
- linux_prio  out  2  latched priority
- tx_queue_idx  out  2  latched queue index
- tx_pkt_sn  out  SN_W  latched SN

Behaviour:
- Reset: state=IDLE. All outputs 0; retrans_cnt=0; timer=0. Reset mid-operation discards the packet with no completion pulse.
- States: IDLE, TX, WAIT_ACK, RETRANS, WAIT_RESTART, REPORT.
- IDLE, on tx_start:
  - latch prio, queue_idx, sn, need_ack and max_num_retrans into internal regs.
  - retrans_cnt=0; go to TX.
  - Later changes on pkt_* or max_num_retrans are ignored until IDLE.
- TX, on tx_end:
  - need_ack=0 -> REPORT, fail=0.
  - need_ack=1 -> load timer=0, go to WAIT_ACK.
  - tx_start in TX is ignored.
- WAIT_ACK: timer increments each cycle.
  - ack_rx&ack_addr_match -> REPORT, fail=0.
  - else timer==max(ack_timeout_top,1)-1 and retrans_cnt==latched max -> REPORT, fail=1.
  - else on timeout -> RETRANS.
  - ACK and timeout in the same cycle: ACK wins.
  - ack_rx without ack_addr_match is ignored.
- RETRANS (1 cycle): retrans_req=1; retrans_cnt++ (saturates at 15); go to WAIT_RESTART.
- WAIT_RESTART: on tx_start -> TX. Metadata is not re-latched. There is no timeout.
- REPORT (1 cycle):
  - tx_try_complete=1; tx_status={fail,retrans_cnt}.
  - linux_prio/tx_queue_idx/tx_pkt_sn drive the latched values; go to IDLE.
- Output timing:
  - Completion pulse appears exactly 1 cycle after the qualifying event (tx_end / ACK / final timeout).
  - Metadata outputs and tx_status are registered and update only on entering REPORT. They hold afterwards until the next REPORT.
- max_num_retrans=0: first timeout reports fail with cnt=0.
- tx_start while in REPORT is lost. Upstream guarantees it only follows busy=0.

Decomposition:
- Package tx_intf_pkg holds:
  - state enum;
  - TX_STATUS_FAIL_BIT=4;
  - TX_STATUS_CNT_MSB=3;
  - default SN_W.
- One natural sub-module: ack_wait_timer. It takes a load/clear, an enable and ack_timeout_top, and produces an expire pulse.

Test Plan:
- No-ACK packet: tx_start (prio=2,q=1,sn=0x155), tx_end 50 cycles later -> tx_try_complete 1 cycle after tx_end, tx_status=5'h00, sn=0x155.
- ACK first try: need_ack=1, timeout_top=100, matched ack_rx at 40 cycles after tx_end -> complete next cycle, status=5'h00, no retrans_req.
- Two retries then ACK: max=3, no ACK twice -> two retrans_req pulses, each followed by tx_start; ACK on third try -> status=5'h02.
- Exhausted: max=2, never ACK -> 2 retrans_req pulses, then complete 1 cycle after third timeout, status=5'h12.
- Boundaries, each giving the stated result:
  - ack_rx coincident with timeout -> success status.
  - unmatched ack_rx -> ignored, retry proceeds.
  - timeout_top=0 -> 1-cycle wait.
- Reset mid-WAIT_ACK: deassert rstn for 1 cycle -> busy=0, no tx_try_complete; a fresh packet afterwards reports correctly.
